pipe_addsub: RTL and testbench

Parametrised, pipelined add/subtract unit with valid/ready flow control. It is the successor to the fixed 10-bit registered adder. Operand width and pipeline depth are generics, and each transaction selects add or subtract. The carry chain is split into NSEG registered segments so wide operands close timing. It sits between a producer and consumer that both use valid/ready handshakes.

---
 rtl/pipe_addsub_pkg.sv | 15 +
 rtl/addsub_seg.sv | 78 +++++++
 rtl/pipe_addsub.sv | 101 ++++++++++
 tb/tb_pipe_addsub.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_addsub_pkg.sv
// pipe_addsub_pkg: shared types and elaboration checks for the pipelined
// add/subtract unit (pipe_addsub and its segment stage addsub_seg).
package pipe_addsub_pkg;

   typedef enum logic {
      MODE_ADD = 1'b0,
      MODE_SUB = 1'b1
   } mode_t;

   // The operand must split into NSEG equal carry-chain segments.
   function automatic bit seg_ok(input int w, input int nseg);
      return (nseg >= 1) && (w >= nseg) && ((w % nseg) == 0);
   endfunction

endpackage

// File: rtl/addsub_seg.sv
// addsub_seg: one carry-chain segment of pipe_addsub. Adds segment K of the
// operands with the carry from the previous stage, merges the partial result
// into the running result word and registers everything for the next stage.
// The whole stage holds while adv_i is low.
module addsub_seg
   import pipe_addsub_pkg::*;
#(
   parameter int W  = 10,
   parameter int SW = 5,
   parameter int K  = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         adv_i,
   input  logic         vld_i,
   input  mode_t        mode_i,
   input  logic         cin_i,
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic [W-1:0] r_i,
   output logic         vld_o,
   output mode_t        mode_o,
   output logic         cout_o,
   output logic [W-1:0] a_o,
   output logic [W-1:0] b_o,
   output logic [W-1:0] r_o
);

   localparam int LSB = K * SW;

   logic [SW-1:0] a_seg;
   logic [SW-1:0] b_seg;
   logic [SW:0]   seg_sum;
   logic [W-1:0]  r_d;

   logic          vld_q;
   mode_t         mode_q;
   logic          cy_q;
   logic [W-1:0]  a_q;
   logic [W-1:0]  b_q;
   logic [W-1:0]  r_q;

   // Segment adder: B is inverted for subtract; the stage-0 carry-in supplies the +1.
   always_comb begin
      a_seg   = a_i[LSB +: SW];
      b_seg   = b_i[LSB +: SW] ^ {SW{mode_i == MODE_SUB}};
      seg_sum = {1'b0, a_seg} + {1'b0, b_seg} + {{SW{1'b0}}, cin_i};
      r_d     = r_i;
      r_d[LSB +: SW] = seg_sum[SW-1:0];
   end

   // Stage register: shifts forward on adv_i, otherwise holds; reset clears all.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q  <= 1'b0;
         mode_q <= MODE_ADD;
         cy_q   <= 1'b0;
         a_q    <= '0;
         b_q    <= '0;
         r_q    <= '0;
      end else if (adv_i) begin
         vld_q  <= vld_i;
         mode_q <= mode_i;
         cy_q   <= seg_sum[SW];
         a_q    <= a_i;
         b_q    <= b_i;
         r_q    <= r_d;
      end
   end

   assign vld_o  = vld_q;
   assign mode_o = mode_q;
   assign cout_o = cy_q;
   assign a_o    = a_q;
   assign b_o    = b_q;
   assign r_o    = r_q;

endmodule

// File: rtl/pipe_addsub.sv
// pipe_addsub: parametrised, pipelined add/subtract with valid/ready flow
// control. The W-bit carry chain is split into NSEG registered segments, one
// per pipeline stage. A single global advance enable moves the whole pipe;
// bubbles are not compressed. out_sum = {carry (add) / borrow (sub), result}.
// Optional feature macro: PIPE_ADDSUB_OVF_EN adds the out_ovf signed-overflow
// output, derived from the operand sign bits carried through the pipe.
module pipe_addsub
   import pipe_addsub_pkg::*;
#(
   parameter int W    = 10,
   parameter int NSEG = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   input  logic         in_mode,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W:0]   out_sum
`ifdef PIPE_ADDSUB_OVF_EN
   ,
   output logic         out_ovf
`endif
);

   localparam int SW = W / NSEG;

   if (!seg_ok(W, NSEG)) begin : g_bad_cfg
      $error("pipe_addsub: W must be a positive multiple of NSEG");
   end

   logic         adv;
   logic         vld_p  [NSEG];
   mode_t        mode_p [NSEG];
   logic         cy_p   [NSEG];
   logic [W-1:0] a_p    [NSEG];
   logic [W-1:0] b_p    [NSEG];
   logic [W-1:0] r_p    [NSEG];

   // The pipe moves whenever the output stage is empty or being consumed.
   assign adv      = ~vld_p[NSEG-1] | out_ready;
   assign in_ready = adv;

   for (genvar k = 0; k < NSEG; k++) begin : g_seg
      if (k == 0) begin : g_first
         addsub_seg #(.W(W), .SW(SW), .K(k)) u_seg (
            .clk    (clk),
            .rst_n  (rst_n),
            .adv_i  (adv),
            .vld_i  (in_valid & adv),
            .mode_i (mode_t'(in_mode)),
            .cin_i  (in_mode),
            .a_i    (in_a),
            .b_i    (in_b),
            .r_i    ({W{1'b0}}),
            .vld_o  (vld_p[k]),
            .mode_o (mode_p[k]),
            .cout_o (cy_p[k]),
            .a_o    (a_p[k]),
            .b_o    (b_p[k]),
            .r_o    (r_p[k])
         );
      end else begin : g_rest
         addsub_seg #(.W(W), .SW(SW), .K(k)) u_seg (
            .clk    (clk),
            .rst_n  (rst_n),
            .adv_i  (adv),
            .vld_i  (vld_p[k-1]),
            .mode_i (mode_p[k-1]),
            .cin_i  (cy_p[k-1]),
            .a_i    (a_p[k-1]),
            .b_i    (b_p[k-1]),
            .r_i    (r_p[k-1]),
            .vld_o  (vld_p[k]),
            .mode_o (mode_p[k]),
            .cout_o (cy_p[k]),
            .a_o    (a_p[k]),
            .b_o    (b_p[k]),
            .r_o    (r_p[k])
         );
      end
   end

   // Subtract reports borrow, the inverse of the final carry.
   assign out_valid = vld_p[NSEG-1];
   assign out_sum   = {cy_p[NSEG-1] ^ (mode_p[NSEG-1] == MODE_SUB), r_p[NSEG-1]};

`ifdef PIPE_ADDSUB_OVF_EN
   logic sgn_a;
   logic sgn_b_eff;

   // Overflow when the effective operands agree in sign but the result does not.
   assign sgn_a     = a_p[NSEG-1][W-1];
   assign sgn_b_eff = b_p[NSEG-1][W-1] ^ (mode_p[NSEG-1] == MODE_SUB);
   assign out_ovf   = (sgn_a == sgn_b_eff) && (r_p[NSEG-1][W-1] != sgn_a);
`endif

endmodule

// File: tb/tb_pipe_addsub.sv
// tb_pipe_addsub: scoreboard bench for pipe_addsub (W=10, NSEG=2). Accepted
// transactions push the reference result; an output monitor pops and compares.
`timescale 1ns/1ps
module tb_pipe_addsub;

   localparam int W    = 10;
   localparam int NSEG = 2;

   logic         clk       = 1'b0;
   logic         rst_n     = 1'b0;
   logic         in_valid  = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_a      = '0;
   logic [W-1:0] in_b      = '0;
   logic         in_mode   = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W:0]   out_sum;
`ifdef PIPE_ADDSUB_OVF_EN
   logic         out_ovf;
`endif

   int           checks = 0;
   int           errors = 0;
   int           n_out  = 0;
   bit           rdy_rand = 1'b0;
   logic [W+1:0] exp_q [$];

   pipe_addsub #(.W(W), .NSEG(NSEG)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum)
`ifdef PIPE_ADDSUB_OVF_EN
      ,
      .out_ovf   (out_ovf)
`endif
   );

   always #5 clk = ~clk;

   // Reference: {ovf, carry/borrow, result} from plain integer arithmetic.
   function automatic logic [W+1:0] ref_txn(input int a, input int b, input bit m);
      int full;
      int half;
      int sa;
      int sbv;
      int res;
      int sum;
      bit ovf;
      full = 1 << W;
      half = 1 << (W - 1);
      sa   = (a >= half) ? a - full : a;
      sbv  = (b >= half) ? b - full : b;
      if (!m) begin
         sum = a + b;
         res = sa + sbv;
      end else begin
         sum = ((a - b + full) % full) + ((a < b) ? full : 0);
         res = sa - sbv;
      end
      ovf = (res >= half) || (res < -half);
      return {ovf, sum[W:0]};
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, got, exp);
      end
   endtask

   // Acceptance monitor: one expected result per handshake; reset discards all.
   initial forever begin
      @(negedge clk);
      if (!rst_n) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back(ref_txn(int'(in_a), int'(in_b), in_mode));
   end

   // Output monitor: compares retiring results and checks output stability under stall.
   initial begin
      bit           held_v;
      logic [W:0]   held_sum;
      logic [W+1:0] e;
      held_v   = 1'b0;
      held_sum = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            held_v = 1'b0;
         end else begin
            if (held_v) begin
               chk("hold_valid", 32'(out_valid), 32'd1);
               chk("hold_sum", 32'(out_sum), 32'(held_sum));
            end
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_out got %0h expected none", out_sum);
               end else begin
                  e = exp_q.pop_front();
                  chk("sum", 32'(out_sum), 32'(e[W:0]));
`ifdef PIPE_ADDSUB_OVF_EN
                  chk("ovf", 32'(out_ovf), 32'(e[W+1]));
`endif
                  n_out++;
               end
            end
            held_v   = out_valid && !out_ready;
            held_sum = out_sum;
         end
      end
   end

   // Random consumer back-pressure, active only during the random phase.
   initial forever begin
      @(posedge clk);
      #1;
      if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
   end

   // Present one transaction until accepted; returns 1 ns after the accepting edge.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
      bit acc;
      int n;
      acc      = 1'b0;
      n        = 0;
      in_a     = a;
      in_b     = b;
      in_mode  = m;
      in_valid = 1'b1;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL send_timeout got no accept expected accept");
      end
      in_valid = 1'b0;
   endtask

   // Single transaction on an empty pipe with out_ready high: latency and value.
   task automatic run_one(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic m, input logic [W:0] exp_sum);
      send(a, b, m);
      chk({name, "_lat_early"}, 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
      chk({name, "_lat"}, 32'(out_valid), 32'd1);
      chk({name, "_sum"}, 32'(out_sum), 32'(exp_sum));
      @(posedge clk);
      #1;
   endtask

`ifdef PIPE_ADDSUB_OVF_EN
   task automatic run_ovf(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic m, input logic exp_ovf);
      send(a, b, m);
      @(posedge clk);
      #1;
      chk({name, "_vld"}, 32'(out_valid), 32'd1);
      chk({name, "_ovf"}, 32'(out_ovf), 32'(exp_ovf));
      @(posedge clk);
      #1;
   endtask
`endif

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain", 32'(exp_q.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n_before;
      int gap;
      logic [W-1:0] ra;
      logic [W-1:0] rb;

      // Reset state, with out_ready low so in_ready reflects the empty pipe.
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_sum", 32'(out_sum), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef PIPE_ADDSUB_OVF_EN
      chk("rst_out_ovf", 32'(out_ovf), 32'd0);
`endif
      rst_n     = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;

      // Directed arithmetic.
      run_one("add_max", 10'd1023, 10'd1023, 1'b0, 11'h7FE);
      run_one("add_segcarry", 10'd31, 10'd1, 1'b0, 11'd32);
      run_one("sub_pos", 10'd300, 10'd100, 1'b1, 11'd200);
      run_one("sub_borrow", 10'd5, 10'd7, 1'b1, {1'b1, 10'h3FE});

`ifdef PIPE_ADDSUB_OVF_EN
      run_ovf("ovf_addpos", 10'd511, 10'd1, 1'b0, 1'b1);
      run_ovf("ovf_subneg", 10'h200, 10'd1, 1'b1, 1'b1);
      run_ovf("ovf_none", 10'd100, 10'd100, 1'b0, 1'b0);
`endif

      // Four back-to-back adds with a 3-cycle consumer stall once output is valid.
      n_before = n_out;
      fork
         begin
            for (int i = 0; i < 4; i++) send(10'(10 * i + 1), 10'(3 * i + 2), 1'b0);
         end
         begin
            int n;
            logic [W:0] hs;
            n = 0;
            while (!out_valid && n < 50) begin
               @(posedge clk);
               #1;
               n++;
            end
            out_ready = 1'b0;
            #1;
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            hs = out_sum;
            chk("stall_first", 32'(hs), 32'd3);
            repeat (3) begin
               @(posedge clk);
               #1;
               chk("stall_valid", 32'(out_valid), 32'd1);
               chk("stall_sum", 32'(out_sum), 32'(hs));
            end
            out_ready = 1'b1;
         end
      join
      drain();
      chk("stall_count", 32'(n_out - n_before), 32'd4);

      // Reset with two transactions in flight.
      send(10'd7, 10'd8, 1'b0);
      send(10'd9, 10'd1, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", 32'(out_valid), 32'd0);
      chk("midrst_sum", 32'(out_sum), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      repeat (5) begin
         @(posedge clk);
         #1;
         chk("midrst_stale", 32'(out_valid), 32'd0);
      end

      // Randomised traffic with random gaps and random back-pressure.
      n_before = n_out;
      rdy_rand = 1'b1;
      for (int i = 0; i < 300; i++) begin
         ra = 10'($urandom);
         rb = 10'($urandom);
         if ($urandom_range(0, 7) == 0) ra = ($urandom_range(0, 1) != 0) ? 10'h3FF : 10'h200;
         if ($urandom_range(0, 7) == 0) rb = ($urandom_range(0, 1) != 0) ? 10'h1FF : 10'h000;
         send(ra, rb, 1'($urandom));
         gap = int'($urandom_range(0, 2));
         repeat (gap) begin
            @(posedge clk);
            #1;
         end
      end
      rdy_rand = 1'b0;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      drain();
      chk("random_count", 32'(n_out - n_before), 32'd300);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global time limit.
   initial begin
      #500000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
